// File: rtl/shift_add_mult_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : shift_add_mult_ctrl_pkg
// Purpose : Shared definitions for the sequential shift-and-add multiplier.
//           Holds the controller state encoding, the default operand width
//           and the helper that sizes the iteration counter.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package shift_add_mult_ctrl_pkg;

    // Default operand width; the product is twice this wide.
    localparam int WIDTH_DEF = 16;

    // Controller states. Encoding 2'd3 is unused and steers back to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Iteration counter width: enough bits to hold 0 .. width-1.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int CNT_W_DEF = cnt_width(WIDTH_DEF);

endpackage : shift_add_mult_ctrl_pkg
`default_nettype wire

// File: rtl/shift_add_mult_ctrl_rca_adder16.sv
`default_nettype none
// ============================================================================
// Module  : rca_adder16
// Purpose : Combinational WIDTH-bit ripple-carry adder built from a chain of
//           full adders, each stage fed by the previous stage's carry.
// Ports   : a    [WIDTH-1:0] in   addend A
//           b    [WIDTH-1:0] in   addend B
//           cin              in   carry in
//           sum  [WIDTH-1:0] out  sum
//           cout             out  carry out of the top stage
// Rev     : 1.0  initial release
// ============================================================================
module rca_adder16
    import shift_add_mult_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        logic half;
        assign half         = a[i] ^ b[i];
        assign sum[i]       = half ^ carry[i];
        assign carry[i + 1] = (half & carry[i]) | (a[i] & b[i]);
    end

    assign cout = carry[WIDTH];

endmodule : rca_adder16
`default_nettype wire

// File: rtl/shift_add_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : shift_add_mult_ctrl
// Purpose : Sequential unsigned WIDTH x WIDTH -> 2*WIDTH multiplier. One
//           shared ripple-carry adder is stepped through WIDTH shift-and-add
//           iterations; latency is fixed at WIDTH+1 cycles from acceptance.
// Ports   : clk, rst_n            clock, async active-low reset
//           in_valid/in_ready     operand handshake (ready only in IDLE)
//           a, b     [WIDTH-1:0]  multiplicand / multiplier, unsigned
//           out_valid/out_ready   result handshake (valid only in DONE)
//           product  [2W-1:0]     registered result, stable while valid
//           busy                  high while iterating
// Rev     : 1.0  initial release
// ============================================================================
module shift_add_mult_ctrl
    import shift_add_mult_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int               CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_t             state_q,   state_d;
    logic [WIDTH-1:0]   mcand_q,   mcand_d;
    logic [WIDTH-1:0]   acc_hi_q,  acc_hi_d;
    logic [WIDTH-1:0]   acc_lo_q,  acc_lo_d;
    logic [CNT_W-1:0]   count_q,   count_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;
    logic [2*WIDTH-1:0] shifted;

    // Multiplier LSB selects whether the multiplicand is added this step.
    assign addend = acc_lo_q[0] ? mcand_q : '0;

    rca_adder16 #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a    (acc_hi_q),
        .b    (addend),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // {cout,sum,acc_lo} >> 1 : the carry becomes the new top bit so a
    // full-scale partial sum is never truncated.
    assign shifted = {add_cout, add_sum, acc_lo_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        count_d   = count_q;
        product_d = product_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d  = a;
                    acc_hi_d = '0;
                    acc_lo_d = b;
                    count_d  = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                acc_hi_d = shifted[2*WIDTH-1:WIDTH];
                acc_lo_d = shifted[WIDTH-1:0];
                count_d  = count_q + CNT_W'(1);
                if (count_q == LAST) begin
                    product_d = shifted;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake outputs decode registered state only, so neither ready nor
    // valid depends combinationally on the opposite side's strobe.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN);
    assign product   = product_q;

endmodule : shift_add_mult_ctrl
`default_nettype wire

// File: tb/tb_shift_add_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_shift_add_mult_ctrl
// Purpose : Self-checking bench for shift_add_mult_ctrl. Expected products
//           come from plain integer multiplication of the offered operands.
// Rev     : 1.0  initial release
// ============================================================================
module tb_shift_add_mult_ctrl;

    localparam int WIDTH = 16;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] product;
    logic               busy;

    int n_total = 0;
    int n_bad   = 0;

    shift_add_mult_ctrl #(
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
        longint unsigned p;
        p = longint'(x) * longint'(y);
        return p[31:0];
    endfunction

    // One complete transaction: offer, watch the run, hold DONE for
    // 'hold' cycles with out_ready low, then complete the handshake.
    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb, input int hold);
        logic [31:0] exp;
        int lat, busy_cnt, irdy_low;
        exp = ref_mul(ta, tb);
        @(negedge clk);
        check_val("idle_in_ready", 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        a         = ta;
        b         = tb;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat      = 1;
        busy_cnt = 0;
        irdy_low = 0;
        forever begin
            if (!in_ready) irdy_low++;
            if (out_valid || lat >= 40) break;
            if (busy) busy_cnt++;
            // Operand churn and stray strobes while not IDLE must be ignored.
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            if (lat < 14) begin
                in_valid  = 1'($urandom);
                out_ready = 1'($urandom);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        check_val("latency", 64'(lat), 64'd17);
        check_val("busy_cycles", 64'(busy_cnt), 64'd16);
        check_val("in_ready_low", 64'(irdy_low), 64'd17);
        check_val("product", 64'(product), 64'(exp));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom);
            @(negedge clk);
            check_val("hold_valid", 64'(out_valid), 64'd1);
            check_val("hold_product", 64'(product), 64'(exp));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_val("post_hs_in_ready", 64'(in_ready), 64'd1);
        check_val("post_hs_out_valid", 64'(out_valid), 64'd0);
        check_val("post_hs_product", 64'(product), 64'(exp));
    endtask

    task automatic back_to_back();
        logic [15:0] pa[4];
        logic [15:0] pb[4];
        logic [31:0] exp_q[$];
        int idx, got, cyc;
        for (int i = 0; i < 4; i++) begin
            pa[i] = WIDTH'($urandom);
            pb[i] = WIDTH'($urandom);
        end
        idx = 0;
        got = 0;
        cyc = 0;
        @(negedge clk);
        in_valid  = 1'b1;
        a         = pa[0];
        b         = pb[0];
        out_ready = 1'($urandom);
        while (got < 4 && cyc < 400) begin
            // Decide what the coming rising edge will transfer.
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("b2b_unexpected_result", 64'(product), 64'd0 - 64'd1);
                end else begin
                    check_val("b2b_product", 64'(product), 64'(exp_q.pop_front()));
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_mul(a, b));
                idx++;
            end
            @(negedge clk);
            cyc++;
            in_valid  = (idx < 4);
            a         = (idx < 4) ? pa[idx] : WIDTH'($urandom);
            b         = (idx < 4) ? pb[idx] : WIDTH'($urandom);
            out_ready = 1'($urandom);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_val("b2b_results", 64'(got), 64'd4);
        check_val("b2b_accepted", 64'(idx), 64'd4);
        check_val("b2b_leftover", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (3) @(negedge clk);
        check_val("rst_in_ready", 64'(in_ready), 64'd1);
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_product", 64'(product), 64'd0);
        rst_n = 1'b1;

        do_op(16'd3, 16'd5, 0);
        do_op(16'hFFFF, 16'hFFFF, 0);
        do_op(16'h8000, 16'h0002, 0);
        do_op(16'h0000, 16'h1234, 0);
        do_op(16'h1234, 16'h5678, 5);
        check_val("plan_1234x5678", 64'(product), 64'h0626_0060);

        // Abort in the middle of an iteration run.
        @(negedge clk);
        in_valid = 1'b1;
        a        = 16'hBEEF;
        b        = 16'hCAFE;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        check_val("mid_run_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check_val("abort_in_ready", 64'(in_ready), 64'd1);
        check_val("abort_out_valid", 64'(out_valid), 64'd0);
        check_val("abort_busy", 64'(busy), 64'd0);
        check_val("abort_product", 64'(product), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(16'd7, 16'd9, 1);
        check_val("plan_7x9", 64'(product), 64'h0000_003F);

        for (int i = 0; i < 4; i++) begin
            do_op(WIDTH'($urandom), WIDTH'($urandom), int'($urandom_range(0, 3)));
        end

        back_to_back();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_shift_add_mult_ctrl
`default_nettype wire
